// File: rtl/cheshire_decerr_slv.sv
// AXI decode-error slave: absorbs unmapped requests and answers every B/R with DECERR.
// Optional fault log (first offending address) enabled by defining CHESHIRE_DECERR_LOG_EN.
module cheshire_decerr_slv #(
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned DataWidth = 64,
    parameter logic [63:0] RespData  = 64'hBADC_AB1E_BADC_AB1E
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
`ifdef CHESHIRE_DECERR_LOG_EN
    output logic                 err_valid_o,
    output logic [AddrWidth-1:0] err_addr_o,
    input  logic                 err_clr_i,
`endif
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic                 w_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [7:0]           ar_len_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o
);

    localparam logic [1:0] RespDecErr = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA} r_state_e;

    w_state_e             w_state_reg, w_state_next;
    logic [IdWidth-1:0]   w_id_reg, w_id_next;
    r_state_e             r_state_reg, r_state_next;
    logic [IdWidth-1:0]   r_id_reg, r_id_next;
    logic [7:0]           r_len_reg, r_len_next;
    logic [7:0]           r_cnt_reg, r_cnt_next;

    // ---------------- write path ----------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            w_state_reg <= W_IDLE;
            w_id_reg    <= '0;
        end else begin
            w_state_reg <= w_state_next;
            w_id_reg    <= w_id_next;
        end
    end

    // Handshake outputs are gated with rst_ni so nothing is offered while reset is held.
    always_comb begin
        w_state_next = w_state_reg;
        w_id_next    = w_id_reg;
        aw_ready_o   = 1'b0;
        w_ready_o    = 1'b0;
        b_valid_o    = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                aw_ready_o = rst_ni;
                if (aw_valid_i) begin
                    w_state_next = W_DATA;
                    w_id_next    = aw_id_i;
                end
            end
            W_DATA: begin
                w_ready_o = rst_ni;
                if (w_valid_i && w_last_i) begin
                    w_state_next = W_RESP;
                end
            end
            W_RESP: begin
                b_valid_o = rst_ni;
                if (b_ready_i) begin
                    w_state_next = W_IDLE;
                end
            end
            default: begin
                w_state_next = W_IDLE;
            end
        endcase
    end

    assign b_id_o   = w_id_reg;
    assign b_resp_o = RespDecErr;

    // ---------------- read path ----------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state_reg <= R_IDLE;
            r_id_reg    <= '0;
            r_len_reg   <= '0;
            r_cnt_reg   <= '0;
        end else begin
            r_state_reg <= r_state_next;
            r_id_reg    <= r_id_next;
            r_len_reg   <= r_len_next;
            r_cnt_reg   <= r_cnt_next;
        end
    end

    always_comb begin
        r_state_next = r_state_reg;
        r_id_next    = r_id_reg;
        r_len_next   = r_len_reg;
        r_cnt_next   = r_cnt_reg;
        ar_ready_o   = 1'b0;
        r_valid_o    = 1'b0;
        case (r_state_reg)
            R_IDLE: begin
                ar_ready_o = rst_ni;
                if (ar_valid_i) begin
                    r_state_next = R_DATA;
                    r_id_next    = ar_id_i;
                    r_len_next   = ar_len_i;
                    r_cnt_next   = 8'd0;
                end
            end
            R_DATA: begin
                r_valid_o = rst_ni;
                if (r_ready_i) begin
                    r_cnt_next = r_cnt_reg + 8'd1;
                    if (r_cnt_reg == r_len_reg) begin
                        r_state_next = R_IDLE;
                    end
                end
            end
            default: begin
                r_state_next = R_IDLE;
            end
        endcase
    end

    assign r_id_o   = r_id_reg;
    assign r_resp_o = RespDecErr;
    assign r_last_o = (r_cnt_reg == r_len_reg);

    // Response pattern repeats every 64 bits, so any data width is filled.
    for (genvar gi = 0; gi < DataWidth; gi++) begin : g_resp_data
        assign r_data_o[gi] = RespData[gi % 64];
    end

    // ---------------- fault log ----------------
`ifdef CHESHIRE_DECERR_LOG_EN
    logic                 aw_hs, ar_hs;
    logic                 err_valid_reg, err_valid_next;
    logic [AddrWidth-1:0] err_addr_reg, err_addr_next;

    assign aw_hs = aw_ready_o & aw_valid_i;
    assign ar_hs = ar_ready_o & ar_valid_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_valid_reg <= 1'b0;
            err_addr_reg  <= '0;
        end else begin
            err_valid_reg <= err_valid_next;
            err_addr_reg  <= err_addr_next;
        end
    end

    // A clear re-arms the log in the same cycle, so a coincident request is captured.
    always_comb begin
        err_valid_next = err_valid_reg;
        err_addr_next  = err_addr_reg;
        if (err_clr_i) begin
            err_valid_next = 1'b0;
        end
        if (!err_valid_reg || err_clr_i) begin
            if (aw_hs) begin
                err_valid_next = 1'b1;
                err_addr_next  = aw_addr_i;
            end else if (ar_hs) begin
                err_valid_next = 1'b1;
                err_addr_next  = ar_addr_i;
            end
        end
    end

    assign err_valid_o = err_valid_reg;
    assign err_addr_o  = err_addr_reg;
`else
    logic unused_addr;
    assign unused_addr = ^{aw_addr_i, ar_addr_i};
`endif

endmodule

// File: tb/tb_cheshire_decerr_slv.sv
// Self-checking bench for cheshire_decerr_slv: queue-based response model plus directed scenarios.
// Fault-log checks are built when CHESHIRE_DECERR_LOG_EN is defined.
module tb_cheshire_decerr_slv;

    localparam int AW = 48;
    localparam int IW = 4;
    localparam int DW = 64;
    localparam logic [63:0] EXP_DATA = 64'hBADCAB1EBADCAB1E;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          aw_valid, aw_ready, w_valid, w_ready, w_last;
    logic          b_valid, b_ready, ar_valid, ar_ready;
    logic          r_valid, r_ready, r_last;
    logic [IW-1:0] aw_id, b_id, ar_id, r_id;
    logic [AW-1:0] aw_addr, ar_addr;
    logic [7:0]    ar_len;
    logic [1:0]    b_resp, r_resp;
    logic [DW-1:0] r_data;
    logic          err_clr;
`ifdef CHESHIRE_DECERR_LOG_EN
    logic          err_valid;
    logic [AW-1:0] err_addr;
`endif

    always #5 clk = ~clk;

    cheshire_decerr_slv #(
        .AddrWidth (AW),
        .IdWidth   (IW),
        .DataWidth (DW)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
`ifdef CHESHIRE_DECERR_LOG_EN
        .err_valid_o(err_valid),
        .err_addr_o (err_addr),
        .err_clr_i  (err_clr),
`endif
        .aw_valid_i (aw_valid),
        .aw_ready_o (aw_ready),
        .aw_id_i    (aw_id),
        .aw_addr_i  (aw_addr),
        .w_valid_i  (w_valid),
        .w_ready_o  (w_ready),
        .w_last_i   (w_last),
        .b_valid_o  (b_valid),
        .b_ready_i  (b_ready),
        .b_id_o     (b_id),
        .b_resp_o   (b_resp),
        .ar_valid_i (ar_valid),
        .ar_ready_o (ar_ready),
        .ar_id_i    (ar_id),
        .ar_addr_i  (ar_addr),
        .ar_len_i   (ar_len),
        .r_valid_o  (r_valid),
        .r_ready_i  (r_ready),
        .r_id_o     (r_id),
        .r_data_o   (r_data),
        .r_resp_o   (r_resp),
        .r_last_o   (r_last)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: outstanding work as queues of expected responses.
    typedef struct {
        logic [IW-1:0] id;
        logic          last;
    } rbeat_t;

    rbeat_t        r_q[$];
    logic [IW-1:0] wq[$];
    logic [IW-1:0] bq[$];
    bit            m_ready = 1'b0;
    logic          m_err_v;
    logic [AW-1:0] m_err_a;

    int            r_hs_cnt = 0, r_last_cnt = 0, r_last_idx = 0, r_burst = 0;
    int            b_hs_cnt = 0;
    logic [IW-1:0] seen_r_id, seen_b_id;

    // Inputs are stable from posedge+1 until the next posedge, so at the negedge the
    // bench both checks current outputs and advances the model for the coming edge.
    initial begin
        forever begin
            bit e_awr, e_wr, e_bv, e_arr, e_rv;
            @(negedge clk);
            e_awr = rst_ni && wq.size() == 0 && bq.size() == 0;
            e_wr  = rst_ni && wq.size() > 0;
            e_bv  = rst_ni && bq.size() > 0;
            e_arr = rst_ni && r_q.size() == 0;
            e_rv  = rst_ni && r_q.size() > 0;
            if (m_ready) begin
                check("aw_ready", aw_ready, e_awr);
                check("w_ready", w_ready, e_wr);
                check("b_valid", b_valid, e_bv);
                check("ar_ready", ar_ready, e_arr);
                check("r_valid", r_valid, e_rv);
                if (e_bv) begin
                    check("b_id", b_id, bq[0]);
                    check("b_resp", b_resp, 2'b11);
                end
                if (e_rv) begin
                    check("r_id", r_id, r_q[0].id);
                    check("r_last", r_last, r_q[0].last);
                    check("r_data", r_data, EXP_DATA);
                    check("r_resp", r_resp, 2'b11);
                end
`ifdef CHESHIRE_DECERR_LOG_EN
                check("err_valid", err_valid, m_err_v);
                check("err_addr", err_addr, m_err_a);
`endif
            end
            // Handshake monitor for the directed scenarios.
            if (rst_ni && r_valid === 1'b1 && r_ready) begin
                r_hs_cnt++;
                r_burst++;
                seen_r_id = r_id;
                if (r_last) begin
                    r_last_cnt++;
                    r_last_idx = r_hs_cnt;
                    $display("R burst id=%0d beats=%0d resp=%0d", r_id, r_burst, r_resp);
                    r_burst = 0;
                end
            end
            if (rst_ni && b_valid === 1'b1 && b_ready) begin
                b_hs_cnt++;
                seen_b_id = b_id;
                $display("B id=%0d resp=%0d", b_id, b_resp);
            end
            if (!rst_ni) begin
                r_q.delete();
                wq.delete();
                bq.delete();
                m_err_v = 1'b0;
                m_err_a = '0;
                r_burst = 0;
                m_ready = 1'b1;
            end else if (m_ready) begin
                bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
                aw_hs = e_awr && aw_valid;
                w_hs  = e_wr && w_valid;
                b_hs  = e_bv && b_ready;
                ar_hs = e_arr && ar_valid;
                r_hs  = e_rv && r_ready;
                if ((aw_hs || ar_hs) && (!m_err_v || err_clr)) begin
                    m_err_v = 1'b1;
                    m_err_a = aw_hs ? aw_addr : ar_addr;
                end else if (err_clr) begin
                    m_err_v = 1'b0;
                end
                if (b_hs) void'(bq.pop_front());
                if (w_hs && w_last) bq.push_back(wq.pop_front());
                if (aw_hs) wq.push_back(aw_id);
                if (r_hs) void'(r_q.pop_front());
                if (ar_hs) begin
                    for (int k = 0; k <= int'(ar_len); k++) begin
                        rbeat_t bt;
                        bt.id   = ar_id;
                        bt.last = (k == int'(ar_len));
                        r_q.push_back(bt);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, lbase, bbase;
        rst_ni = 1'b0;
        aw_valid = 0; aw_id = '0; aw_addr = '0;
        w_valid = 0; w_last = 0; b_ready = 1;
        ar_valid = 0; ar_id = '0; ar_addr = '0; ar_len = '0;
        r_ready = 1; err_clr = 0;
        repeat (3) tick();
        check("rst_aw_ready", aw_ready, 1'b0);
        check("rst_ar_ready", ar_ready, 1'b0);
        check("rst_b_valid", b_valid, 1'b0);
        check("rst_r_valid", r_valid, 1'b0);
        rst_ni = 1'b1;
        #1;
        check("release_aw_ready", aw_ready, 1'b1);
        check("release_ar_ready", ar_ready, 1'b1);
        tick();

        // Write burst of 4 beats; B follows the last W handshake by one cycle.
        aw_valid = 1; aw_id = 4'd3; aw_addr = 48'h1_0000_0000;
        tick();
        aw_valid = 0;
        w_valid = 1;
        for (int i = 0; i < 4; i++) begin
            w_last = (i == 3);
            if (i == 3) check("b_early", b_valid, 1'b0);
            tick();
        end
        w_valid = 0; w_last = 0;
        check("b_valid_after_last", b_valid, 1'b1);
        check("b_id_3", b_id, 4'd3);
        check("b_resp_decerr", b_resp, 2'b11);
        tick();
        check("aw_ready_after_b", aw_ready, 1'b1);
        check("b_valid_after_b", b_valid, 1'b0);

        // Read burst len=7 under alternating backpressure.
        base = r_hs_cnt; lbase = r_last_cnt;
        ar_valid = 1; ar_id = 4'd5; ar_len = 8'd7;
        tick();
        ar_valid = 0;
        for (int i = 0; i < 100 && (r_hs_cnt - base) < 8; i++) begin
            r_ready = (i % 2 == 0);
            tick();
        end
        r_ready = 1;
        repeat (3) tick();
        check("len7_beats", r_hs_cnt - base, 8);
        check("len7_last_cnt", r_last_cnt - lbase, 1);
        check("len7_last_on_8th", r_last_idx - base, 8);
        check("len7_id", seen_r_id, 4'd5);
        check("len7_idle", r_valid, 1'b0);

        // Simultaneous AW and AR (256-beat read).
        base = r_hs_cnt; bbase = b_hs_cnt;
        aw_valid = 1; aw_id = 4'd1; aw_addr = 48'h40;
        ar_valid = 1; ar_id = 4'd2; ar_len = 8'd255; ar_addr = 48'h80;
        tick();
        aw_valid = 0; ar_valid = 0;
        check("both_accepted_aw", aw_ready, 1'b0);
        check("both_accepted_ar", ar_ready, 1'b0);
        w_valid = 1; w_last = 1;
        tick();
        w_valid = 0; w_last = 0;
        for (int i = 0; i < 400 && ((r_hs_cnt - base) < 256 || (b_hs_cnt - bbase) < 1); i++) tick();
        repeat (2) tick();
        check("len255_beats", r_hs_cnt - base, 256);
        check("len255_last_on_256th", r_last_idx - base, 256);
        check("len255_r_id", seen_r_id, 4'd2);
        check("sim_b_count", b_hs_cnt - bbase, 1);
        check("sim_b_id", seen_b_id, 4'd1);

        // Reset after the 3rd of 8 beats abandons the burst.
        base = r_hs_cnt;
        ar_valid = 1; ar_id = 4'd6; ar_len = 8'd7;
        tick();
        ar_valid = 0;
        for (int i = 0; i < 20 && (r_hs_cnt - base) < 3; i++) tick();
        rst_ni = 0;
        tick();
        rst_ni = 1;
        #1;
        check("post_rst_ar_ready", ar_ready, 1'b1);
        check("post_rst_r_valid", r_valid, 1'b0);
        repeat (10) tick();
        check("rst_abandon_beats", r_hs_cnt - base, 3);

`ifdef CHESHIRE_DECERR_LOG_EN
        err_clr = 1;
        tick();
        err_clr = 0;
        check("log_cleared", err_valid, 1'b0);
        aw_valid = 1; aw_id = 4'd0; aw_addr = 48'hA0;
        tick();
        aw_valid = 0; w_valid = 1; w_last = 1;
        tick();
        w_valid = 0; w_last = 0;
        tick();
        check("log_valid_a0", err_valid, 1'b1);
        check("log_addr_a0", err_addr, 48'hA0);
        ar_valid = 1; ar_id = 4'd0; ar_len = 8'd0; ar_addr = 48'hB0;
        tick();
        ar_valid = 0;
        tick();
        check("log_sticky_addr", err_addr, 48'hA0);
        ar_valid = 1; ar_addr = 48'hC0; err_clr = 1;
        tick();
        ar_valid = 0; err_clr = 0;
        check("log_set_wins_valid", err_valid, 1'b1);
        check("log_set_wins_addr", err_addr, 48'hC0);
        tick();
        err_clr = 1;
        tick();
        err_clr = 0;
        check("log_clear_only", err_valid, 1'b0);
        tick();
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
